multiexp_dispatch: RTL and testbench

- Front-end stage directly upstream of the multiexp top level.
- Accepts a host stream of (scalar, affine point) elements, one 256-bit field per beat.
- Assembles each element and hands it to one of NUM_CORES multiexp cores in strict round-robin, so the cores compute partial multiexps in parallel.
- Signals end-of-batch so the downstream adder can start combining core results.

---
 rtl/bn128_pkg.sv | 21 ++
 rtl/multiexp_rr_ptr.sv | 34 +++
 rtl/multiexp_dispatch.sv | 148 ++++++++++++++
 tb/tb_multiexp_dispatch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bn128_pkg.sv
// Shared BN128 multiexp types: field element, assembled element, dispatcher states.
package bn128_pkg;

    localparam int FE_BITS = 256;

    typedef logic [FE_BITS-1:0] fe_t;

    typedef struct packed {
        fe_t y;
        fe_t x;
        fe_t scalar;
    } multiexp_elem_t;

    typedef enum logic [1:0] {
        RX_S = 2'd0,
        RX_X = 2'd1,
        RX_Y = 2'd2,
        TX   = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/multiexp_rr_ptr.sv
// Round-robin core pointer modulo NUM_CORES with advance/clear and one-hot decode.
module multiexp_rr_ptr #(
    parameter int NUM_CORES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_adv,
    input  logic                 i_clr,
    output logic [NUM_CORES-1:0] o_onehot
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_clr) begin
            ptr_d = '0;
        end else if (i_adv) begin
            ptr_d = (ptr_q == PTR_W'(NUM_CORES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_onehot = NUM_CORES'(1) << ptr_q;

endmodule

// File: rtl/multiexp_dispatch.sv
// Assembles {y, x, scalar} from a 3-beat host stream and dispatches each element to the
// next multiexp core in strict round-robin. Option: MULTIEXP_DISPATCH_SKIP_ZERO_EN.
module multiexp_dispatch
    import bn128_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int FLD_BITS  = 256,
    parameter int CNT_BITS  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FLD_BITS-1:0]   i_dat,
    input  logic                  i_val,
    input  logic                  i_last,
    output logic                  o_rdy,
    output logic [3*FLD_BITS-1:0] o_elem,
    output logic [NUM_CORES-1:0]  o_val,
    input  logic [NUM_CORES-1:0]  i_core_rdy,
    output logic                  o_batch_done,
    output logic [CNT_BITS-1:0]   o_count,
    output logic                  o_err
);

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + CNT_BITS'(1);
    endfunction

    dispatch_state_e       state_q, state_d;
    logic [FLD_BITS-1:0]   scalar_q, scalar_d;
    logic [FLD_BITS-1:0]   x_q, x_d;
    logic [FLD_BITS-1:0]   y_q, y_d;
    logic                  last_q, last_d;
    logic                  rdy_q, rdy_d;
    logic [NUM_CORES-1:0]  val_q, val_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_BITS-1:0]   count_q, count_d;

    logic                  beat, frame_err, y_beat, drop, dispatch, retire_last;
    logic [NUM_CORES-1:0]  tgt_oh;

    assign beat      = i_val && rdy_q;
    assign frame_err = beat && i_last && (state_q == RX_S || state_q == RX_X);
    assign y_beat    = beat && (state_q == RX_Y);
    assign dispatch  = (state_q == TX) && |(i_core_rdy & tgt_oh);

`ifdef MULTIEXP_DISPATCH_SKIP_ZERO_EN
    assign drop = y_beat && (scalar_q == '0);
`else
    assign drop = 1'b0;
`endif

    // A dropped last element still closes the batch.
    assign retire_last = (dispatch && last_q) || (drop && i_last);

    multiexp_rr_ptr #(
        .NUM_CORES(NUM_CORES)
    ) u_rr_ptr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_adv    (dispatch || drop),
        .i_clr    (retire_last),
        .o_onehot (tgt_oh)
    );

    always_comb begin
        state_d  = state_q;
        scalar_d = scalar_q;
        x_d      = x_q;
        y_d      = y_q;
        last_d   = last_q;
        unique case (state_q)
            RX_S: if (beat) begin
                if (frame_err) begin
                    state_d = RX_S;
                end else begin
                    scalar_d = i_dat;
                    state_d  = RX_X;
                end
            end
            RX_X: if (beat) begin
                if (frame_err) begin
                    state_d = RX_S;
                end else begin
                    x_d     = i_dat;
                    state_d = RX_Y;
                end
            end
            RX_Y: if (beat) begin
                y_d     = i_dat;
                last_d  = i_last;
                state_d = drop ? RX_S : TX;
            end
            TX: if (dispatch) begin
                state_d = RX_S;
            end
            default: state_d = RX_S;
        endcase

        rdy_d  = (state_d != TX);
        val_d  = (state_d == TX) ? tgt_oh : '0;
        done_d = retire_last;
        err_d  = frame_err;

        // The final count is shown alongside the done pulse, then cleared.
        if (done_q) begin
            count_d = '0;
        end else if (dispatch) begin
            count_d = sat_inc(count_q);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= RX_S;
            scalar_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            last_q   <= 1'b0;
            rdy_q    <= 1'b0;
            val_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            scalar_q <= scalar_d;
            x_q      <= x_d;
            y_q      <= y_d;
            last_q   <= last_d;
            rdy_q    <= rdy_d;
            val_q    <= val_d;
            done_q   <= done_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign o_rdy        = rdy_q;
    assign o_elem       = {y_q, x_q, scalar_q};
    assign o_val        = val_q;
    assign o_batch_done = done_q;
    assign o_count      = count_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_multiexp_dispatch.sv
// Directed + randomized bench for multiexp_dispatch against an element-index reference model.
module tb_multiexp_dispatch;

    localparam int NC = 4;
    localparam int FB = 256;
    localparam int CB = 32;
`ifdef MULTIEXP_DISPATCH_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            i_rst;
    logic [FB-1:0]   i_dat;
    logic            i_val;
    logic            i_last;
    logic            o_rdy;
    logic [3*FB-1:0] o_elem;
    logic [NC-1:0]   o_val;
    logic [NC-1:0]   i_core_rdy;
    logic            o_batch_done;
    logic [CB-1:0]   o_count;
    logic            o_err;

    int checks = 0;
    int errors = 0;
    // Reference model: element index within the batch and dispatched count.
    int k_m     = 0;
    int count_m = 0;

    multiexp_dispatch #(
        .NUM_CORES(NC),
        .FLD_BITS (FB),
        .CNT_BITS (CB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_dat       (i_dat),
        .i_val       (i_val),
        .i_last      (i_last),
        .o_rdy       (o_rdy),
        .o_elem      (o_elem),
        .o_val       (o_val),
        .i_core_rdy  (i_core_rdy),
        .o_batch_done(o_batch_done),
        .o_count     (o_count),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3*FB-1:0] obs, input logic [3*FB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FB-1:0] rand_fe();
        logic [FB-1:0] r;
        for (int i = 0; i < FB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NC-1:0] target_oh();
        return NC'(1) << (k_m % NC);
    endfunction

    task automatic beat(input logic [FB-1:0] d, input logic l);
        int n;
        @(negedge clk);
        i_val = 1'b1; i_dat = d; i_last = l;
        n = 0;
        while (o_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: o_rdy=%b, required 1", o_rdy);
        end
    endtask

    task automatic send_elem(input logic [FB-1:0] s, input logic last, input int stall);
        logic [FB-1:0] x, y;
        logic [NC-1:0] oh;
        bit            drop;
        x    = rand_fe();
        y    = rand_fe();
        oh   = target_oh();
        drop = SKIP && (s == '0);
        if (stall > 0) i_core_rdy = NC'($urandom) & ~oh;
        else           i_core_rdy = NC'($urandom) | oh;
        beat(s, 1'b0);
        beat(x, 1'b0);
        beat(y, last);
        @(negedge clk);
        i_val = 1'b0; i_last = 1'b0;
        if (drop) begin
            chk("drop_no_val", o_val, '0);
            chk("drop_rdy", o_rdy, 1'b1);
            k_m++;
        end else begin
            chk("tx_val", o_val, oh);
            chk("tx_elem", o_elem, {y, x, s});
            chk("tx_rdy", o_rdy, 1'b0);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_val", o_val, oh);
                chk("stall_elem", o_elem, {y, x, s});
                chk("stall_rdy", o_rdy, 1'b0);
            end
            i_core_rdy = NC'($urandom) | oh;
            @(negedge clk);
            k_m++;
            count_m++;
            chk("post_val", o_val, '0);
            chk("post_rdy", o_rdy, 1'b1);
        end
        if (last) begin
            chk("done_pulse", o_batch_done, 1'b1);
            chk("done_count", o_count, CB'(count_m));
            @(negedge clk);
            chk("done_clear", o_batch_done, 1'b0);
            chk("count_clear", o_count, '0);
            k_m = 0;
            count_m = 0;
        end else begin
            chk("no_done", o_batch_done, 1'b0);
            chk("count", o_count, CB'(count_m));
        end
    endtask

    initial begin
        int len;
        i_rst = 1'b0; i_val = 1'b0; i_last = 1'b0; i_dat = '0; i_core_rdy = '1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy", o_rdy, 1'b0);
        chk("rst_val", o_val, '0);
        chk("rst_elem", o_elem, '0);
        chk("rst_done", o_batch_done, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_count", o_count, '0);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", o_rdy, 1'b1);

        // Batch of 8, scalars 1..8, all cores ready
        for (int i = 1; i <= 8; i++) send_elem(FB'(i), i == 8, 0);

        // Core 1 stalls 20 cycles on element 2
        for (int i = 1; i <= 4; i++) send_elem(FB'(i), i == 4, (i == 2) ? 20 : 0);

        // Framing errors on an x beat and on a scalar beat keep ptr and count
        send_elem(FB'(10), 1'b0, 0);
        send_elem(FB'(11), 1'b0, 0);
        beat(FB'(99), 1'b0);
        beat(rand_fe(), 1'b1);
        @(negedge clk);
        i_val = 1'b0; i_last = 1'b0;
        chk("ferr_x_pulse", o_err, 1'b1);
        chk("ferr_x_val", o_val, '0);
        chk("ferr_x_count", o_count, CB'(count_m));
        chk("ferr_x_done", o_batch_done, 1'b0);
        @(negedge clk);
        chk("ferr_x_once", o_err, 1'b0);
        beat(FB'(98), 1'b1);
        @(negedge clk);
        i_val = 1'b0; i_last = 1'b0;
        chk("ferr_s_pulse", o_err, 1'b1);
        chk("ferr_s_val", o_val, '0);
        send_elem(FB'(12), 1'b1, 0);

        // Batch of 5 then batch of 3
        for (int i = 0; i < 5; i++) send_elem(rand_fe() | FB'(1), i == 4, 0);
        for (int i = 0; i < 3; i++) send_elem(rand_fe() | FB'(1), i == 2, 0);

        // Reset while in TX
        send_elem(FB'(21), 1'b0, 0);
        i_core_rdy = '0;
        beat(FB'(22), 1'b0);
        beat(rand_fe(), 1'b0);
        beat(rand_fe(), 1'b0);
        @(negedge clk);
        i_val = 1'b0;
        chk("rst_tx_val", o_val, target_oh());
        #3 i_rst = 1'b0;
        #1;
        chk("rst_async_val", o_val, '0);
        chk("rst_async_rdy", o_rdy, 1'b0);
        chk("rst_async_count", o_count, '0);
        @(negedge clk);
        i_rst = 1'b1;
        i_core_rdy = '1;
        k_m = 0;
        count_m = 0;
        @(negedge clk);
        chk("rst_release_rdy", o_rdy, 1'b1);
        send_elem(FB'(23), 1'b1, 0);

        // Zero scalar in the middle of a batch
        send_elem(FB'(3), 1'b0, 0);
        send_elem(FB'(0), 1'b0, 0);
        send_elem(FB'(7), 1'b1, 0);

        // Zero scalar as the last element
        send_elem(FB'(5), 1'b0, 0);
        send_elem(FB'(0), 1'b1, 0);

        // Randomized batches with random stalls and occasional zero scalars
        for (int b = 0; b < 4; b++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                send_elem(($urandom_range(0, 3) == 0) ? FB'(0) : rand_fe(),
                          i == len - 1, $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
